// File: rtl/paula_disk_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module  : paula_disk_fifo_pkg
// Brief   : Shared defaults and output-select encoding for the disk DMA FIFO.
// Revision: 1.0
// ============================================================================
package paula_disk_fifo_pkg;

  localparam int DEF_DW     = 16;
  localparam int DEF_AW     = 11;
  localparam int DEF_AF_LVL = 1792;
  localparam int DEF_AE_LVL = 256;

  // Source of the head-of-queue word presented on out.
  typedef enum logic [1:0] {
    OUT_ZERO = 2'd0,
    OUT_RAM  = 2'd1,
    OUT_BYP  = 2'd2
  } out_sel_e;

endpackage
`default_nettype wire

// File: rtl/paula_fifo_ram.sv
`default_nettype none
// ============================================================================
// Module  : paula_fifo_ram
// Brief   : Simple dual-port sync RAM, registered read, read-before-write.
// Revision: 1.0
// ============================================================================
module paula_fifo_ram
  import paula_disk_fifo_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(2**AW)-1];
  logic [DW-1:0] rdata_q;
  logic [DW-1:0] rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[raddr];
  end

  // Read samples the old word when the write hits the same address.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/paula_disk_fifo.sv
`default_nettype none
// ============================================================================
// Module  : paula_disk_fifo
// Brief   : Show-ahead disk DMA FIFO with write bypass, thresholds and flags.
// Revision: 1.0
// ============================================================================
module paula_disk_fifo
  import paula_disk_fifo_pkg::*;
#(
  parameter int DW     = DEF_DW,
  parameter int AW     = DEF_AW,
  parameter int AF_LVL = DEF_AF_LVL,
  parameter int AE_LVL = DEF_AE_LVL
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clk7_en,
  input  logic          flush,
  input  logic [DW-1:0] in,
  input  logic          wr,
  input  logic          rd,
  input  logic          clr_err,
  output logic [DW-1:0] out,
  output logic          empty,
  output logic          full,
  output logic          afull,
  output logic          aempty,
  output logic [AW:0]   cnt,
  output logic          ovf,
  output logic          udf
);

  localparam logic [AW:0] DEPTH_CNT = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] AF_CNT    = AF_LVL[AW:0];
  localparam logic [AW:0] AE_CNT    = AE_LVL[AW:0];

  logic [AW:0]   in_ptr_q, in_ptr_d;
  logic [AW:0]   out_ptr_q, out_ptr_d;
  logic          empty_q, empty_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;
  out_sel_e      out_sel_q, out_sel_d;
  logic [DW-1:0] byp_q, byp_d;

  logic          rd_acc, wr_acc, advance;
  logic [AW:0]   out_ptr_inc;
  logic [AW-1:0] raddr;
  logic [DW-1:0] ram_rdata;

  assign cnt    = in_ptr_q - out_ptr_q;
  assign full   = (cnt == DEPTH_CNT);
  assign afull  = (cnt >= AF_CNT);
  assign aempty = (cnt <= AE_CNT);
  assign empty  = empty_q;
  assign ovf    = ovf_q;
  assign udf    = udf_q;

  always_comb begin
    advance     = clk7_en & reset_n & ~flush;
    rd_acc      = rd & ~empty_q;
    wr_acc      = wr & (~full | rd_acc);
    out_ptr_inc = out_ptr_q + 1'b1;
    raddr       = rd_acc ? out_ptr_inc[AW-1:0] : out_ptr_q[AW-1:0];
  end

  always_comb begin
    in_ptr_d  = in_ptr_q;
    out_ptr_d = out_ptr_q;
    empty_d   = empty_q;
    ovf_d     = ovf_q;
    udf_d     = udf_q;
    out_sel_d = out_sel_q;
    byp_d     = byp_q;
    if (clk7_en) begin
      if (clr_err) begin
        ovf_d = 1'b0;
        udf_d = 1'b0;
      end
      if (flush) begin
        in_ptr_d  = '0;
        out_ptr_d = '0;
        empty_d   = 1'b1;
      end else begin
        if (wr_acc) in_ptr_d  = in_ptr_q + 1'b1;
        if (rd_acc) out_ptr_d = out_ptr_inc;
        empty_d = (in_ptr_d == out_ptr_d);
        // RAM returns the pre-write word on collision, so forward the input.
        if (wr_acc && (in_ptr_q[AW-1:0] == raddr)) begin
          out_sel_d = OUT_BYP;
          byp_d     = in;
        end else begin
          out_sel_d = OUT_RAM;
        end
        if (wr && !wr_acc) ovf_d = 1'b1;
        if (rd && !rd_acc) udf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clk7_en && !reset_n) begin
      in_ptr_q  <= '0;
      out_ptr_q <= '0;
      empty_q   <= 1'b1;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
      out_sel_q <= OUT_ZERO;
      byp_q     <= '0;
    end else begin
      in_ptr_q  <= in_ptr_d;
      out_ptr_q <= out_ptr_d;
      empty_q   <= empty_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
      out_sel_q <= out_sel_d;
      byp_q     <= byp_d;
    end
  end

  paula_fifo_ram #(
    .DW (DW),
    .AW (AW)
  ) u_ram (
    .clk   (clk),
    .we    (advance & wr_acc),
    .waddr (in_ptr_q[AW-1:0]),
    .wdata (in),
    .re    (advance),
    .raddr (raddr),
    .rdata (ram_rdata)
  );

  always_comb begin
    case (out_sel_q)
      OUT_RAM: out = ram_rdata;
      OUT_BYP: out = byp_q;
      default: out = '0;
    endcase
  end

endmodule
`default_nettype wire
